message_writer: RTL and testbench
=================================

Name: message_writer

Overview:
- Entry-side front end for the scrolling message display: the writer that fills the 32-entry, 5-bit message RAM the scroller reads.
- Debounces push buttons and commits the character-switch value to consecutive RAM addresses.
- Keeps an end-of-message marker after the last character and supports a full-RAM clear sweep.
- Drives the RAM write port (WE/address/data) when the display is in write mode.

Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W = 32.
- DATA_W, 5, character code width.
- DEBOUNCE_CYCLES, 16, consecutive stable clocks required before a debounced level changes (sim uses 4).
- END_CODE, 5'h1F, terminator code written after the last character and by clear.

Ports:
- clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- EN  in  1  write mode (SW); 1 = entry allowed, 0 = all button actions ignored.
- Data_In  in  DATA_W  character code from switches.
- Boton_Write  in  1  raw, bouncing "commit character" button, active-high.
- Boton_Clear  in  1  raw, bouncing "clear message" button, active-high.
- WE_Out  out  1  RAM write enable, one cycle per write.
- Address_Out  out  ADDR_W  RAM write address.
- Data_Out  out  DATA_W  RAM write data.
- Length  out  ADDR_W+1  number of committed characters, 0..32.
- Full  out  1  Length == 32.
- Busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (Reset=0, async): FSM=IDLE, wr_ptr=0, Length=0, WE_Out=0, Address_Out=0, Data_Out=0, Full=0, Busy=0, sync/debounce state=0. RAM contents are not touched.
- Input conditioning per button:
  - 2-FF synchronizer.
  - Debounce counter resets whenever the synced level equals the debounced level; otherwise it increments, and the debounced level flips when the count reaches DEBOUNCE_CYCLES.
  - A rising edge of the debounced level produces a one-cycle commit pulse.
  - Latency: raw high first sampled at edge k -> debounced high at edge k+2+DEBOUNCE_CYCLES -> pulse in that cycle.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: IDLE, WRITE, TERM, CLEAR.
  - IDLE: pulses are acted on only when EN=1.
    - Clear pulse -> CLEAR, with wr_ptr=0. Clear has priority if both pulses occur in the same cycle.
    - Write pulse with Full=0 -> WRITE; Data_In is captured into Data_Out on that edge.
    - Write pulse with Full=1 -> ignored; stay in IDLE.
  - WRITE (1 cycle): WE_Out=1, Address_Out=wr_ptr, Data_Out=captured code. On exit: wr_ptr+1, Length+1. Then go to TERM if new Length<32, else IDLE.
  - TERM (1 cycle): WE_Out=1, Address_Out=wr_ptr, Data_Out=END_CODE. Then IDLE.
  - CLEAR (32 cycles): WE_Out=1 every cycle, Data_Out=END_CODE, Address_Out = 0,1,...,31. After address 31: wr_ptr=0, Length=0, go to IDLE.
- Pulses arriving while Busy=1 are dropped (no queueing).
- EN falling while Busy=1: the current WRITE/TERM/CLEAR sequence completes.
- wr_ptr wraps naturally 31->0, but is never used at Length=32 because writes are blocked when Full.
- Reset asserted mid-CLEAR or mid-WRITE: immediate return to the reset state; a partial RAM sweep is allowed.
- WE_Out is 0 in IDLE. Address_Out/Data_Out hold their last values in IDLE.

Test Plan:
- Reset then idle; DEBOUNCE_CYCLES=4 -> all outputs 0, Busy=0, Length=0.
- EN=1, Data_In=5'h0A, Boton_Write held high 10 cycles -> exactly one WE_Out pulse with addr 0/data 0A, then next cycle addr 1/data 1F; Length=1. WRITE pulse occurs at edge k+2+4+1.
- Boton_Write toggling every 2 cycles for 20 cycles, then low -> no WE_Out, Length unchanged.
- 32 commits of codes 0..31 -> Length=32, Full=1, no TERM after the 32nd write; a 33rd press gives no WE_Out.
- Clear pulse with Length=7 -> 32 consecutive WE_Out cycles at addrs 0..31 with data 1F, Busy=1 throughout; Length=0 after.
- EN=0 with both buttons pressed -> no WE_Out. Reset pulled low at cycle 10 of CLEAR -> Busy=0 and WE_Out=0 immediately; after release, a write goes to addr 0.

Source files
------------

// File: rtl/message_writer.sv
// Writer front end for the scrolling message RAM: debounces the commit/clear buttons
// and drives the RAM write port with characters, an end marker, or a full clear sweep.
module message_writer #(
  parameter int                ADDR_W          = 5,
  parameter int                DATA_W          = 5,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter logic [DATA_W-1:0] END_CODE        = 5'h1F
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              EN,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Boton_Write,
  input  logic              Boton_Clear,
  output logic              WE_Out,
  output logic [ADDR_W-1:0] Address_Out,
  output logic [DATA_W-1:0] Data_Out,
  output logic [ADDR_W:0]   Length,
  output logic              Full,
  output logic              Busy,
  output logic [1:0]        State_Dbg
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_TERM  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Button conditioning; index 0 = write button, index 1 = clear button.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [1:0]       r_deb_d;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       w_pulse;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int b = 0; b < 2; b++) r_cnt[b] <= '0;
    end else begin
      r_sync1 <= {Boton_Clear, Boton_Write};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_MAX) begin
          r_deb[b] <= r_sync2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_pulse = r_deb & ~r_deb_d;

  // Sequencer state and write-port registers.
  state_t            r_state,   w_state_nx;
  logic [ADDR_W-1:0] r_wr_ptr,  w_ptr_nx;
  logic [ADDR_W:0]   r_len,     w_len_nx;
  logic [ADDR_W-1:0] r_addr,    w_addr_nx;
  logic [DATA_W-1:0] r_data,    w_data_nx;
  logic [ADDR_W:0]   w_len_inc;
  logic              w_full;

  assign w_full    = (r_len == LEN_FULL);
  assign w_len_inc = r_len + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_wr_ptr;
    w_len_nx   = r_len;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    case (r_state)
      S_IDLE: begin
        // Clear wins when both pulses land in the same cycle.
        if (EN && w_pulse[1]) begin
          w_state_nx = S_CLEAR;
          w_ptr_nx   = '0;
          w_addr_nx  = '0;
          w_data_nx  = END_CODE;
        end else if (EN && w_pulse[0] && !w_full) begin
          w_state_nx = S_WRITE;
          w_addr_nx  = r_wr_ptr;
          w_data_nx  = Data_In;
        end
      end
      S_WRITE: begin
        w_ptr_nx = r_wr_ptr + 1'b1;
        w_len_nx = w_len_inc;
        if (w_len_inc != LEN_FULL) begin
          w_state_nx = S_TERM;
          w_addr_nx  = r_wr_ptr + 1'b1;
          w_data_nx  = END_CODE;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_TERM: begin
        w_state_nx = S_IDLE;
      end
      S_CLEAR: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nx = S_IDLE;
          w_ptr_nx   = '0;
          w_len_nx   = '0;
        end else begin
          w_addr_nx = r_addr + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_len    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_wr_ptr <= w_ptr_nx;
      r_len    <= w_len_nx;
      r_addr   <= w_addr_nx;
      r_data   <= w_data_nx;
    end
  end

  // Every non-idle state issues exactly one RAM write per cycle.
  assign WE_Out      = (r_state != S_IDLE);
  assign Busy        = (r_state != S_IDLE);
  assign Address_Out = r_addr;
  assign Data_Out    = r_data;
  assign Length      = r_len;
  assign Full        = w_full;
  assign State_Dbg   = r_state;

endmodule

// File: tb/tb_message_writer.sv
// Bench for message_writer: random button stimulus against a queue-based model of
// the RAM write stream (address/data pairs) plus committed length.
module tb_message_writer;

  localparam int             AW   = 5;
  localparam int             DW   = 5;
  localparam int             DEB  = 4;
  localparam logic [DW-1:0]  ENDC = 5'h1F;

  logic          clock = 1'b0;
  logic          Reset = 1'b0;
  logic          EN = 1'b0;
  logic [DW-1:0] Data_In = '0;
  logic          Boton_Write = 1'b0;
  logic          Boton_Clear = 1'b0;
  logic          WE_Out;
  logic [AW-1:0] Address_Out;
  logic [DW-1:0] Data_Out;
  logic [AW:0]   Length;
  logic          Full;
  logic          Busy;
  logic [1:0]    State_Dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  int m_len = 0;
  int m_ptr = 0;

  message_writer #(
    .ADDR_W(AW), .DATA_W(DW), .DEBOUNCE_CYCLES(DEB), .END_CODE(ENDC)
  ) dut (
    .clock(clock), .Reset(Reset), .EN(EN), .Data_In(Data_In),
    .Boton_Write(Boton_Write), .Boton_Clear(Boton_Clear),
    .WE_Out(WE_Out), .Address_Out(Address_Out), .Data_Out(Data_Out),
    .Length(Length), .Full(Full), .Busy(Busy), .State_Dbg(State_Dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (Reset && WE_Out) obs_q.push_back({Address_Out, Data_Out});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Boton_Write = 1'b0;
    Boton_Clear = 1'b0;
    step(3);
    Reset = 1'b1;
    step(3);
    m_len = 0;
    m_ptr = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // reference model: what the RAM write port must show for each accepted action
  task automatic model_write(input logic [DW-1:0] code);
    if (EN && m_len < 32) begin
      exp_q.push_back({AW'(m_ptr), code});
      m_ptr = (m_ptr + 1) % 32;
      m_len = m_len + 1;
      if (m_len < 32) exp_q.push_back({AW'(m_ptr), ENDC});
    end
  endtask

  task automatic model_clear();
    if (EN) begin
      for (int a = 0; a < 32; a++) exp_q.push_back({AW'(a), ENDC});
      m_len = 0;
      m_ptr = 0;
    end
  endtask

  // drivers
  task automatic press_write(input logic [DW-1:0] code);
    Data_In = code;
    Boton_Write = 1'b1;
    step($urandom_range(8, 14));
    Boton_Write = 1'b0;
    step(14);
    model_write(code);
  endtask

  task automatic press_clear();
    Boton_Clear = 1'b1;
    step($urandom_range(8, 14));
    Boton_Clear = 1'b0;
    step(45);
    model_clear();
  endtask

  task automatic press_both();
    Data_In = 5'($urandom_range(0, 31));
    Boton_Write = 1'b1;
    Boton_Clear = 1'b1;
    step($urandom_range(8, 14));
    Boton_Write = 1'b0;
    Boton_Clear = 1'b0;
    step(45);
    model_clear();
  endtask

  task automatic bounce(input bit on_clear, input bit fixed2);
    logic lvl;
    int t;
    int w;
    lvl = 1'b0;
    t = 0;
    while (t < 20) begin
      lvl = ~lvl;
      if (on_clear) Boton_Clear = lvl; else Boton_Write = lvl;
      w = fixed2 ? 2 : int'($urandom_range(1, 3));
      step(w);
      t = t + w;
    end
    Boton_Write = 1'b0;
    Boton_Clear = 1'b0;
    step(14);
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    step(5);
    n_vec++; if (WE_Out !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", WE_Out); end
    n_vec++; if (Address_Out !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", Address_Out); end
    n_vec++; if (Data_Out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", Data_Out); end
    n_vec++; if (Length !== '0) begin n_err++; $display("FAIL reset_len: got %0d want 0", Length); end
    n_vec++; if (Full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", Full); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_vec++; if (State_Dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", State_Dbg); end
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_writes: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_single_write();
    int first;
    do_reset();
    EN = 1'b1;
    Data_In = 5'h0A;
    Boton_Write = 1'b1;
    first = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (WE_Out && first < 0) first = i;
      if (i == 9) Boton_Write = 1'b0;
    end
    step(14);
    model_write(5'h0A);
    n_vec++; if (first !== 2 + DEB + 1) begin n_err++; $display("FAIL write_latency: got %0d want %0d", first, 2 + DEB + 1); end
    n_vec++; if (Length !== (AW+1)'(m_len)) begin n_err++; $display("FAIL single_len: got %0d want %0d", Length, m_len); end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    int len0;
    len0 = m_len;
    EN = 1'b1;
    bounce(1'b0, 1'b1);
    bounce(1'b1, 1'b1);
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL bounce_writes: got %0d want 0", obs_q.size()); end
    n_vec++; if (Length !== (AW+1)'(len0)) begin n_err++; $display("FAIL bounce_len: got %0d want %0d", Length, len0); end
    obs_q.delete();
  endtask

  task automatic test_en_low();
    EN = 1'b0;
    press_both();
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL en_low_writes: got %0d want 0", obs_q.size()); end
    n_vec++; if (Length !== (AW+1)'(m_len)) begin n_err++; $display("FAIL en_low_len: got %0d want %0d", Length, m_len); end
    EN = 1'b1;
    step(2);
    obs_q.delete();
  endtask

  task automatic test_fill();
    do_reset();
    EN = 1'b1;
    for (int i = 0; i < 32; i++) press_write(5'(i));
    n_vec++; if (Length !== 6'd32) begin n_err++; $display("FAIL fill_len: got %0d want 32", Length); end
    n_vec++; if (Full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", Full); end
    press_write(5'($urandom_range(0, 31)));
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL fill_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fill_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear();
    int waited;
    EN = 1'b1;
    press_clear();
    for (int i = 0; i < 7; i++) press_write(5'($urandom_range(0, 31)));
    n_vec++; if (Length !== 6'd7) begin n_err++; $display("FAIL clear_pre_len: got %0d want 7", Length); end
    Boton_Clear = 1'b1;
    waited = 0;
    do begin @(negedge clock); waited++; end while (!Busy && waited < 30);
    n_vec++; if (!Busy) begin n_err++; $display("FAIL clear_start: got busy=%b want 1 within 30 cycles", Busy); end
    model_clear();
    Boton_Clear = 1'b0;
    EN = 1'b0;
    for (int c = 0; c < 32; c++) begin
      n_vec++;
      if (Busy !== 1'b1 || WE_Out !== 1'b1) begin n_err++; $display("FAIL clear_busy[%0d]: got busy=%b we=%b want 1/1", c, Busy, WE_Out); end
      @(negedge clock);
    end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL clear_end: got busy=%b want 0", Busy); end
    n_vec++; if (Length !== '0) begin n_err++; $display("FAIL clear_len: got %0d want 0", Length); end
    EN = 1'b1;
    step(20);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL clear_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clear_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_clear();
    int waited;
    EN = 1'b1;
    press_write(5'($urandom_range(0, 31)));
    press_write(5'($urandom_range(0, 31)));
    obs_q.delete(); exp_q.delete();
    Boton_Clear = 1'b1;
    waited = 0;
    do begin @(negedge clock); waited++; end while (!Busy && waited < 30);
    n_vec++; if (!Busy) begin n_err++; $display("FAIL midclr_start: got busy=%b want 1 within 30 cycles", Busy); end
    Boton_Clear = 1'b0;
    repeat (9) @(negedge clock);
    #2 Reset = 1'b0;
    #1;
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL midclr_busy: got %b want 0", Busy); end
    n_vec++; if (WE_Out !== 1'b0) begin n_err++; $display("FAIL midclr_we: got %b want 0", WE_Out); end
    n_vec++; if (Length !== '0) begin n_err++; $display("FAIL midclr_len: got %0d want 0", Length); end
    n_vec++; if (obs_q.size() != 10) begin n_err++; $display("FAIL midclr_partial: got %0d want 10", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== {AW'(i), ENDC}) begin n_err++; $display("FAIL midclr_stream[%0d]: got %h want %h", i, obs_q[i], {AW'(i), ENDC}); end
    end
    step(2);
    Reset = 1'b1;
    step(3);
    m_len = 0; m_ptr = 0;
    obs_q.delete(); exp_q.delete();
    press_write(5'($urandom_range(0, 31)));
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL post_reset_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL post_reset_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_mix();
    int op;
    EN = 1'b1;
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) press_write(5'($urandom_range(0, 31)));
      else if (op == 6) press_clear();
      else if (op == 7) bounce(1'($urandom_range(0, 1)), 1'b0);
      else if (op == 8) begin EN = 1'b0; press_both(); EN = 1'b1; step(2); end
      else press_both();
    end
    n_vec++; if (Length !== (AW+1)'(m_len)) begin n_err++; $display("FAIL mix_len: got %0d want %0d", Length, m_len); end
    n_vec++; if (Full !== (m_len == 32)) begin n_err++; $display("FAIL mix_full: got %b want %b", Full, m_len == 32); end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mix_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mix_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_bounce();
    test_en_low();
    test_fill();
    test_clear();
    test_reset_mid_clear();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
